// File: rtl/apb_stream_fifo_slave.sv
// apb_stream_fifo_slave: APB register slave bridging byte FIFOs to streams.
// Ports: PCLK/PRESET (sync, active-high); APB slave PSEL..PSLVERR;
// TX stream TX_DATA/TX_VALID/TX_READY; RX stream RX_DATA/RX_VALID; IRQ level.
module apb_stream_fifo_slave #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

    state_t state_q, state_d, phase;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   prdata_q;
    logic          pready_q, pslverr_q, irq_q;

    logic done, addr_ok, sel_tx, sel_rx, sel_st, sel_ct;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_drop, ctrl_wr;
    logic err_d;
    logic [7:0]  rx_head_d;
    logic [4:0]  tx_cnt_x, rx_cnt_x;
    logic [31:0] status_d, rdata_d;
    logic        unused_bits;

    // The setup phase is an IDLE cycle with PSEL high; the access phase
    // is then tracked in WAIT (PREADY low) and DONE (PREADY high).
    always_comb begin
        phase   = state_q;
        state_d = state_q;
        if (state_q == IDLE && PSEL && !PENABLE) phase = SETUP;
        unique case (phase)
            IDLE:    state_d = IDLE;
            SETUP:   state_d = WAIT;
            WAIT:    state_d = (PSEL && PENABLE) ? DONE : IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done    = PSEL && PENABLE && pready_q;
    assign addr_ok = (PADDR[7:4] == 4'h0);
    assign sel_tx  = addr_ok && (PADDR[3:2] == 2'd0);
    assign sel_rx  = addr_ok && (PADDR[3:2] == 2'd1);
    assign sel_st  = addr_ok && (PADDR[3:2] == 2'd2);
    assign sel_ct  = addr_ok && (PADDR[3:2] == 2'd3);

    assign tx_push = done && PWRITE && sel_tx && (tx_cnt_q != FULL);
    assign tx_pop  = TX_VALID && TX_READY;
    assign rx_pop  = done && !PWRITE && sel_rx && (rx_cnt_q != '0);
    // A full RX FIFO still accepts a byte when an APB pop frees a slot.
    assign rx_push = RX_VALID && ((rx_cnt_q != FULL) || rx_pop);
    assign rx_drop = RX_VALID && (rx_cnt_q == FULL) && !rx_pop;
    assign ctrl_wr = done && PWRITE && sel_ct;

    always_comb begin
        tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
        rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
        ctrl_d = ctrl_wr ? PWDATA[1:0] : ctrl_q;
        // A dropped byte wins over a simultaneous clear.
        ovf_d = ovf_q;
        if (rx_drop) ovf_d = 1'b1;
        else if (ctrl_wr && PWDATA[4]) ovf_d = 1'b0;
    end

    // Read data is registered at the WAIT edge from next-state values,
    // i.e. exactly the state that is registered during DONE.
    assign tx_cnt_x  = 5'(tx_cnt_d);
    assign rx_cnt_x  = 5'(rx_cnt_d);
    assign rx_head_d = (rx_push && rx_wr_q == rx_rd_d) ? RX_DATA
                                                       : rx_mem_q[rx_rd_d];
    assign status_d  = {16'h0, rx_cnt_x[3:0], tx_cnt_x[3:0], 3'b0, ovf_d,
                        rx_cnt_d == FULL, rx_cnt_d == '0,
                        tx_cnt_d == FULL, tx_cnt_d == '0};
    assign err_d     = !addr_ok
                     || (PWRITE && sel_tx && tx_cnt_d == FULL)
                     || (!PWRITE && sel_rx && rx_cnt_d == '0);

    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            sel_rx:  rdata_d = {24'h0, rx_head_d};
            sel_st:  rdata_d = status_d;
            sel_ct:  rdata_d = {30'h0, ctrl_d};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            pready_q  <= (state_d == DONE);
            pslverr_q <= (state_d == DONE) && err_d;
            prdata_q  <= (state_d == DONE && !PWRITE && !err_d) ? rdata_d : '0;
            irq_q     <= (ctrl_q[0] && rx_cnt_q != '0)
                       || (ctrl_q[1] && tx_cnt_q == '0) || ovf_q;
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= PWDATA[7:0];
        if (rx_push) rx_mem_q[rx_wr_q] <= RX_DATA;
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign TX_DATA  = tx_mem_q[tx_rd_q];
    assign TX_VALID = (tx_cnt_q != '0);
    assign IRQ      = irq_q;

    assign unused_bits = ^{PADDR[1:0], PWDATA[31:8], tx_cnt_x[4], rx_cnt_x[4]};
endmodule
